// File: rtl/hdr_sched_pkg.sv
// Shared types and constants for the HDR command scheduler.
// Covers the FSM states, the response status codes and the queue record layouts.
package hdr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_EXIT_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK      = 2'b00,
    RESP_TIMEOUT = 2'b01,
    RESP_ABORT   = 2'b10
  } status_e;

  localparam logic [2:0] HDR_DDR_MODE = 3'd6;

  typedef struct packed {
    logic [3:0] tid;
    logic       cp;
    logic       toc;
    logic [2:0] mode;
  } cmd_t;

  typedef struct packed {
    logic [3:0] tid;
    status_e    status;
  } resp_t;

  localparam int CMD_W  = $bits(cmd_t);
  localparam int RESP_W = $bits(resp_t);

endpackage

// File: rtl/hdr_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible on o_rdata
// whenever o_empty is low. DEPTH must be a power of 2.
module hdr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = i_push && (!full || do_pop);
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hdr_cmd_scheduler.sv
// Issues queued HDR commands to the engine, chains TOC=0 commands back to back,
// and reports each finished command's TID and status through a response queue.
module hdr_cmd_scheduler
  import hdr_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [3:0] i_cmd_tid,
  input  logic       i_cmd_cp,
  input  logic       i_cmd_toc,
  input  logic [2:0] i_cmd_mode,
  output logic       o_hdrengine_en,
  output logic       o_cp,
  output logic       o_toc,
  output logic [2:0] o_mode,
  input  logic       i_xfer_done,
  input  logic       i_hdrengine_done,
  output logic       o_resp_valid,
  input  logic       i_resp_ready,
  output logic [3:0] o_resp_tid,
  output logic [1:0] o_resp_status,
  output logic       o_busy
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e           state_q, state_d;
  cmd_t             active_q, active_d;
  logic             act_v_q, act_v_d;
  logic             en_q, en_d;
  logic             cp_q, cp_d;
  logic             toc_q, toc_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cmd_t        cmd_in, cmd_head;
  logic        cmd_push, cmd_pop, cmd_empty;
  logic [CW-1:0] cmd_count;
  resp_t       resp_wdata, resp_head;
  logic        resp_push, resp_pop, resp_empty;
  logic [CW-1:0] resp_count;
  logic [CW:0] outstanding;
  logic        timeout;

  assign cmd_in   = {i_cmd_tid, i_cmd_cp, i_cmd_toc, i_cmd_mode};
  assign cmd_push = i_cmd_valid && o_cmd_ready;
  assign resp_pop = i_resp_ready && !resp_empty;

  // Counting the active command and unread responses keeps the response queue from overflowing.
  assign outstanding = (CW+1)'(cmd_count) + (CW+1)'(resp_count) + (CW+1)'(act_v_q);
  assign o_cmd_ready = (outstanding < (CW+1)'(DEPTH));
  assign timeout     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  hdr_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_q (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_push  (cmd_push),
    .i_wdata (cmd_in),
    .i_pop   (cmd_pop),
    .o_rdata (cmd_head),
    .o_empty (cmd_empty),
    .o_count (cmd_count)
  );

  hdr_sync_fifo #(.WIDTH(RESP_W), .DEPTH(DEPTH)) u_resp_q (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_push  (resp_push),
    .i_wdata (resp_wdata),
    .i_pop   (resp_pop),
    .o_rdata (resp_head),
    .o_empty (resp_empty),
    .o_count (resp_count)
  );

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    act_v_d    = act_v_q;
    en_d       = en_q;
    cp_d       = cp_q;
    toc_d      = toc_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    cmd_pop    = 1'b0;
    resp_push  = 1'b0;
    resp_wdata = {active_q.tid, RESP_OK};
    case (state_q)
      ST_IDLE: begin
        // A TOC=0 head waits for its successor so the chain target is known before done.
        if (!cmd_empty && (cmd_head.toc || cmd_count >= CW'(2))) begin
          cmd_pop  = 1'b1;
          active_d = cmd_head;
          act_v_d  = 1'b1;
          en_d     = 1'b1;
          cp_d     = cmd_head.cp;
          toc_d    = cmd_head.toc;
          mode_d   = cmd_head.mode;
          cnt_d    = '0;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_xfer_done) begin
          resp_push = 1'b1;
          if (!active_q.toc && !i_hdrengine_done && !cmd_empty) begin
            cmd_pop  = 1'b1;
            active_d = cmd_head;
            cp_d     = cmd_head.cp;
            toc_d    = cmd_head.toc;
            mode_d   = cmd_head.mode;
            cnt_d    = '0;
          end else begin
            act_v_d = 1'b0;
            if (i_hdrengine_done) begin
              en_d    = 1'b0;
              state_d = ST_IDLE;
            end else begin
              // Also reached by a TOC=0 command with nothing to chain: wait for exit or timeout.
              state_d = ST_EXIT_WAIT;
            end
          end
        end else if (i_hdrengine_done || timeout) begin
          resp_push  = 1'b1;
          resp_wdata = {active_q.tid, i_hdrengine_done ? RESP_ABORT : RESP_TIMEOUT};
          act_v_d    = 1'b0;
          en_d       = 1'b0;
          state_d    = ST_IDLE;
        end else if (!active_q.toc && !cmd_empty) begin
          // The engine samples CP in the done cycle, so present the successor's CP early.
          cp_d = cmd_head.cp;
        end
      end
      ST_EXIT_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_hdrengine_done || timeout) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        act_v_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      act_v_q <= 1'b0;
      en_q    <= 1'b0;
      cp_q    <= 1'b0;
      toc_q   <= 1'b0;
      mode_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_v_q <= act_v_d;
      en_q    <= en_d;
      cp_q    <= cp_d;
      toc_q   <= toc_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    active_q <= active_d;
  end

  assign o_hdrengine_en = en_q;
  assign o_cp           = cp_q;
  assign o_toc          = toc_q;
  assign o_mode         = mode_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_resp_valid   = !resp_empty;
  assign o_resp_tid     = resp_empty ? 4'd0 : resp_head.tid;
  assign o_resp_status  = resp_empty ? 2'b00 : resp_head.status;

endmodule
